// File: rtl/awg_pkg.sv
// Shared types and defaults for the AWG frequency-sweep sequencer.
// Holds the FSM state encoding, the sweep-mode encoding and the default widths.
package awg_pkg;

  localparam int FREQ_W_DEF  = 12;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_STEP,
    ST_DONE
  } state_e;

  // Reserved encoding 3 falls through to single-sweep behaviour.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_CONT   = 2'd1,
    MODE_BIDIR  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/awg_sweep_ctrl_if.sv
// Config/control bundle between the front-panel registers and the sweep
// sequencer, plus the generator-facing outputs.
interface awg_sweep_ctrl_if
  import awg_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);

  logic               start;
  logic               stop_req;
  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic [2:0]         cfg_amp;
  logic [7:0]         cfg_phase;

  logic [FREQ_W-1:0]  state_freq;
  logic [2:0]         state_amp;
  logic [7:0]         state_phase;
  logic               gen_en;
  logic               busy;
  logic               dir_down;
  logic               done;

  modport master (
    output start, stop_req, cfg_start_freq, cfg_stop_freq, cfg_step,
           cfg_dwell, cfg_mode, cfg_amp, cfg_phase,
    input  state_freq, state_amp, state_phase, gen_en, busy, dir_down, done
  );

  modport slave (
    input  start, stop_req, cfg_start_freq, cfg_stop_freq, cfg_step,
           cfg_dwell, cfg_mode, cfg_amp, cfg_phase,
    output state_freq, state_amp, state_phase, gen_en, busy, dir_down, done
  );

endinterface

// File: rtl/sweep_step_calc.sv
// Combinational next-point calculator: saturating +/- step toward the active
// leg end, reversing the leg first when the current point already sits on it.
module sweep_step_calc
  import awg_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic [FREQ_W-1:0] cur_i,
  input  logic [FREQ_W-1:0] step_i,
  input  logic [FREQ_W-1:0] lo_i,
  input  logic [FREQ_W-1:0] hi_i,
  input  logic              down_i,
  output logic [FREQ_W-1:0] next_o,
  output logic              at_target_o,
  output logic              next_down_o
);

  logic [FREQ_W-1:0] target;
  logic [FREQ_W-1:0] leg_target;
  logic [FREQ_W:0]   sum;
  logic [FREQ_W:0]   dif;

  assign sum = {1'b0, cur_i} + {1'b0, step_i};
  assign dif = {1'b0, cur_i} - {1'b0, step_i};

  // NOTE: every output is assigned on every path so no latch is inferred.
  always_comb begin
    target      = down_i ? lo_i : hi_i;
    at_target_o = (cur_i == target);
    next_down_o = at_target_o ? ~down_i : down_i;
    leg_target  = next_down_o ? lo_i : hi_i;
    if (step_i == '0) begin
      next_o = leg_target;
    end else if (next_down_o) begin
      // A borrow out of the extra bit means the subtraction wrapped below zero.
      next_o = (dif[FREQ_W] || (dif[FREQ_W-1:0] < leg_target)) ? leg_target : dif[FREQ_W-1:0];
    end else begin
      next_o = (sum > {1'b0, leg_target}) ? leg_target : sum[FREQ_W-1:0];
    end
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the generator frequency word between two
// endpoints, holding each point a programmable number of clocks.
module awg_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic             clk,
  input logic             rst,
  awg_sweep_ctrl_if.slave bus
);

  state_e             state_q;
  mode_e              mode_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_m1_q;
  logic [FREQ_W-1:0]  step_q, lo_q, hi_q, start_freq_q;
  logic [FREQ_W-1:0]  freq_q;
  logic [2:0]         amp_q;
  logic [7:0]         phase_q;
  logic               gen_en_q, busy_q, dir_down_q, done_q;

  logic [DWELL_W-1:0] dwell_m1_d;
  logic [FREQ_W-1:0]  freq_next_d;
  logic               at_target_d, dir_down_d;
  state_e             hold_state_d;

  assign dwell_m1_d   = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - DWELL_W'(1);
  // A one-clock hold skips DWELL entirely: STEP alone is the single cycle.
  assign hold_state_d = (dwell_m1_q == '0) ? ST_STEP : ST_DWELL;

  sweep_step_calc #(.FREQ_W(FREQ_W)) u_step_calc (
    .cur_i       (freq_q),
    .step_i      (step_q),
    .lo_i        (lo_q),
    .hi_i        (hi_q),
    .down_i      (dir_down_q),
    .next_o      (freq_next_d),
    .at_target_o (at_target_d),
    .next_down_o (dir_down_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      cnt_q        <= '0;
      dwell_m1_q   <= '0;
      step_q       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      start_freq_q <= '0;
      freq_q       <= '0;
      amp_q        <= 3'd1;
      phase_q      <= '0;
      gen_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      dir_down_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop_req && (state_q != ST_IDLE)) begin
        state_q  <= ST_IDLE;
        gen_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start && !bus.stop_req) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            mode_q       <= mode_e'(bus.cfg_mode);
            step_q       <= bus.cfg_step;
            start_freq_q <= bus.cfg_start_freq;
            dwell_m1_q   <= dwell_m1_d;
            lo_q         <= (bus.cfg_stop_freq < bus.cfg_start_freq) ? bus.cfg_stop_freq : bus.cfg_start_freq;
            hi_q         <= (bus.cfg_stop_freq < bus.cfg_start_freq) ? bus.cfg_start_freq : bus.cfg_stop_freq;
            dir_down_q   <= (bus.cfg_stop_freq < bus.cfg_start_freq);
            freq_q       <= bus.cfg_start_freq;
            amp_q        <= (bus.cfg_amp == 3'd0) ? 3'd1 : bus.cfg_amp;
            phase_q      <= bus.cfg_phase;
            cnt_q        <= dwell_m1_d;
            state_q      <= (dwell_m1_d == '0) ? ST_STEP : ST_DWELL;
            gen_en_q     <= 1'b1;
          end
          ST_DWELL: begin
            cnt_q <= cnt_q - DWELL_W'(1);
            if (cnt_q == DWELL_W'(1)) state_q <= ST_STEP;
          end
          ST_STEP: begin
            cnt_q   <= dwell_m1_q;
            state_q <= hold_state_d;
            if (!at_target_d) begin
              freq_q <= freq_next_d;
            end else begin
              case (mode_q)
                MODE_CONT: freq_q <= start_freq_q;
                MODE_BIDIR: begin
                  freq_q     <= freq_next_d;
                  dir_down_q <= dir_down_d;
                end
                default: begin
                  state_q  <= ST_DONE;
                  gen_en_q <= 1'b0;
                  done_q   <= 1'b1;
                end
              endcase
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.state_freq  = freq_q;
  assign bus.state_amp   = amp_q;
  assign bus.state_phase = phase_q;
  assign bus.gen_en      = gen_en_q;
  assign bus.busy        = busy_q;
  assign bus.dir_down    = dir_down_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Self-checking bench for awg_sweep_ctrl: a cycle-trace model built from the
// sweep rules is compared against the DUT every cycle, plus literal checks.
module tb_awg_sweep_ctrl;

  localparam int FW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  awg_sweep_ctrl_if #(.FREQ_W(FW), .DWELL_W(DW)) bus ();

  awg_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int freq;
    int amp;
    int phase;
    bit gen_en;
    bit busy;
    bit dir;
    bit done;
  } rec_t;

  rec_t exp_q[$];
  rec_t hold_rec;
  rec_t last_rec;

  int n_cmp = 0;
  int n_bad = 0;
  int seen[$];
  int en_cycles = 0;
  int done_cnt  = 0;
  bit prev_en   = 1'b0;
  int prev_freq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int step_toward(int v, int t, int s);
    if (s == 0) return t;
    if (t > v) return (v + s > t) ? t : v + s;
    if (t < v) return (v - s < t) ? t : v - s;
    return t;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hold_rec.freq   = 0;
    hold_rec.amp    = 1;
    hold_rec.phase  = 0;
    hold_rec.gen_en = 1'b0;
    hold_rec.busy   = 1'b0;
    hold_rec.dir    = 1'b0;
    hold_rec.done   = 1'b0;
    last_rec = hold_rec;
  endtask

  // Expected cycle-by-cycle trace of one sweep, from the configuration alone.
  task automatic build_trace();
    int   s   = bus.cfg_start_freq;
    int   e   = bus.cfg_stop_freq;
    int   st  = bus.cfg_step;
    int   d   = (bus.cfg_dwell == 0) ? 1 : int'(bus.cfg_dwell);
    int   md  = bus.cfg_mode;
    int   amp = (bus.cfg_amp == 0) ? 1 : int'(bus.cfg_amp);
    int   ph  = bus.cfg_phase;
    bit   dir = (e < s);
    int   tgt = e;
    int   v   = s;
    rec_t r;
    r = last_rec;
    r.busy = 1'b1; r.gen_en = 1'b0; r.done = 1'b0;
    exp_q.push_back(r);
    forever begin
      r.freq = v; r.amp = amp; r.phase = ph; r.dir = dir;
      r.gen_en = 1'b1; r.busy = 1'b1; r.done = 1'b0;
      repeat (d) exp_q.push_back(r);
      if (exp_q.size() > 400) break;
      if (v == tgt) begin
        if (md == 1) v = s;
        else if (md == 2) begin
          dir = !dir;
          tgt = (tgt == e) ? s : e;
          v   = step_toward(v, tgt, st);
        end else begin
          r.gen_en = 1'b0; r.done = 1'b1;
          exp_q.push_back(r);
          hold_rec = r;
          hold_rec.done = 1'b0;
          hold_rec.busy = 1'b0;
          break;
        end
      end else begin
        v = step_toward(v, tgt, st);
      end
    end
  endtask

  // Compare process: one model record per cycle, sampled mid-cycle.
  initial begin
    forever begin
      rec_t r;
      @(negedge clk);
      if (exp_q.size() > 0) r = exp_q.pop_front();
      else r = hold_rec;
      check("state_freq",  32'(bus.state_freq),  r.freq);
      check("state_amp",   32'(bus.state_amp),   r.amp);
      check("state_phase", 32'(bus.state_phase), r.phase);
      check("gen_en",      32'(bus.gen_en),      32'(r.gen_en));
      check("busy",        32'(bus.busy),        32'(r.busy));
      check("dir_down",    32'(bus.dir_down),    32'(r.dir));
      check("done",        32'(bus.done),        32'(r.done));
      last_rec = r;
      if (bus.gen_en === 1'b1 && (!prev_en || int'(bus.state_freq) != prev_freq))
        seen.push_back(int'(bus.state_freq));
      if (bus.gen_en === 1'b1) en_cycles++;
      if (bus.done === 1'b1) done_cnt++;
      prev_en   = (bus.gen_en === 1'b1);
      prev_freq = int'(bus.state_freq);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit p);
    bus.start    = s;
    bus.stop_req = p;
    tick();
    bus.start    = 1'b0;
    bus.stop_req = 1'b0;
    if (last_rec.busy) begin
      if (p) begin
        exp_q.delete();
        hold_rec = last_rec;
        hold_rec.busy   = 1'b0;
        hold_rec.gen_en = 1'b0;
        hold_rec.done   = 1'b0;
      end
    end else if (s && !p) begin
      build_trace();
    end
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int dw,
                         input int md, input int amp, input int ph);
    bus.cfg_start_freq = FW'(s);
    bus.cfg_stop_freq  = FW'(e);
    bus.cfg_step       = FW'(st);
    bus.cfg_dwell      = DW'(dw);
    bus.cfg_mode       = 2'(md);
    bus.cfg_amp        = 3'(amp);
    bus.cfg_phase      = 8'(ph);
  endtask

  task automatic clear_mon();
    seen.delete();
    en_cycles = 0;
    done_cnt  = 0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check({name, "_done_cnt"}, done_cnt, 1);
    tick();
    tick();
  endtask

  task automatic check_seq(input string name, input int n, input bit exact, input int e[8]);
    if (exact) check({name, "_points"}, seen.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pt%0d", name, i), (i < seen.size()) ? seen[i] : -1, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.start = 1'b0;
    bus.stop_req = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_state_amp", 32'(bus.state_amp), 1);
    check("rst_gen_en",    32'(bus.gen_en),    0);
    check("rst_busy",      32'(bus.busy),      0);
    tick();
    rst = 1'b0;
    tick();

    // Up single sweep, dwell 3.
    set_cfg(100, 130, 10, 3, 0, 4, 8'h5a);
    clear_mon();
    pulse(1, 0);
    run_until_done("up", 100);
    check_seq("up", 4, 1'b1, '{100, 110, 120, 130, 0, 0, 0, 0});
    check("up_en_cycles", en_cycles, 12);

    // Down with saturation at the last point, amp 0 clamps to 1.
    set_cfg(50, 5, 20, 1, 0, 0, 3);
    clear_mon();
    pulse(1, 0);
    run_until_done("down", 100);
    check_seq("down", 4, 1'b1, '{50, 30, 10, 5, 0, 0, 0, 0});
    check("down_en_cycles", en_cycles, 4);
    check("down_amp_clamp", 32'(bus.state_amp), 1);
    check("down_dir_held", 32'(bus.dir_down), 1);

    // Dwell 0 behaves as dwell 1.
    set_cfg(3, 5, 1, 0, 0, 2, 0);
    clear_mon();
    pulse(1, 0);
    run_until_done("dwell0", 100);
    check_seq("dwell0", 3, 1'b1, '{3, 4, 5, 0, 0, 0, 0, 0});
    check("dwell0_en_cycles", en_cycles, 3);

    // Step 0 jumps straight to the stop value.
    set_cfg(20, 900, 0, 2, 0, 2, 0);
    clear_mon();
    pulse(1, 0);
    run_until_done("step0", 100);
    check_seq("step0", 2, 1'b1, '{20, 900, 0, 0, 0, 0, 0, 0});

    // start == stop in reserved mode: one point then done.
    set_cfg(7, 7, 3, 4, 3, 6, 1);
    clear_mon();
    pulse(1, 0);
    run_until_done("single_pt", 100);
    check_seq("single_pt", 1, 1'b1, '{7, 0, 0, 0, 0, 0, 0, 0});
    check("single_pt_en_cycles", en_cycles, 4);

    // Bidirectional ping-pong, aborted with stop_req.
    set_cfg(0, 4, 2, 1, 2, 3, 9);
    clear_mon();
    pulse(1, 0);
    repeat (9) tick();
    pulse(0, 1);
    check("bidir_gen_en_after_stop", 32'(bus.gen_en), 0);
    repeat (3) tick();
    check_seq("bidir", 7, 1'b0, '{0, 2, 4, 2, 0, 2, 4, 0});
    check("bidir_no_done", done_cnt, 0);

    // Continuous restart; config changes and a second start mid-sweep are ignored.
    set_cfg(10, 12, 1, 2, 1, 5, 7);
    clear_mon();
    pulse(1, 0);
    repeat (3) tick();
    bus.cfg_stop_freq  = FW'(11);
    bus.cfg_start_freq = FW'(40);
    pulse(1, 0);
    repeat (10) tick();
    pulse(0, 1);
    repeat (2) tick();
    check_seq("cont", 5, 1'b0, '{10, 11, 12, 10, 11, 0, 0, 0});
    check("cont_no_done", done_cnt, 0);
    check("cont_busy_after_stop", 32'(bus.busy), 0);

    // start and stop_req together while idle: stays idle.
    set_cfg(1, 9, 1, 1, 0, 1, 0);
    pulse(1, 1);
    repeat (2) tick();
    check("both_idle_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a dwell.
    set_cfg(300, 100, 50, 5, 0, 5, 33);
    pulse(1, 0);
    repeat (3) tick();
    check("pre_rst_freq", 32'(bus.state_freq), 300);
    check("pre_rst_dir", 32'(bus.dir_down), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_freq",  32'(bus.state_freq),  0);
    check("async_rst_amp",   32'(bus.state_amp),   1);
    check("async_rst_phase", 32'(bus.state_phase), 0);
    check("async_rst_gen_en", 32'(bus.gen_en),     0);
    check("async_rst_busy",  32'(bus.busy),        0);
    check("async_rst_dir",   32'(bus.dir_down),    0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/awg_sweep_ctrl.md
Name: awg_sweep_ctrl

Overview:
Sequencer that drives the frequency, amplitude and phase controls of the waveform generators (tri/sine/square) to produce frequency sweeps.
- Steps the frequency word from a start value to a stop value in fixed increments, holding each value for a programmable number of clocks.
- Supports single, continuous-restart and bidirectional (ping-pong) sweeps.
- Sits between the front-panel/config registers and the generator `state_freq`/`state_amp`/`state_phase`/`en` inputs.

Parameters:
- FREQ_W, 12, width of frequency step word (matches generator `state_freq`)
- DWELL_W, 16, width of dwell counter (clocks per frequency point)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; begins sweep when idle
- stop_req  in  1  single-cycle pulse; aborts sweep
- cfg_start_freq  in  FREQ_W  first frequency word
- cfg_stop_freq  in  FREQ_W  last frequency word
- cfg_step  in  FREQ_W  increment magnitude per point
- cfg_dwell  in  DWELL_W  clocks per point; 0 treated as 1
- cfg_mode  in  2  0=single, 1=continuous restart, 2=bidirectional, 3=reserved (treated as single)
- cfg_amp  in  3  amplitude divisor for generator
- cfg_phase  in  8  phase offset for generator
- state_freq  out  FREQ_W  frequency word to generator
- state_amp  out  3  amplitude divisor to generator
- state_phase  out  8  phase to generator
- gen_en  out  1  generator output enable
- busy  out  1  high in any non-IDLE state
- dir_down  out  1  1 while current sweep leg is descending
- done  out  1  one-cycle pulse at natural end of single sweep

Behaviour:
- Reset values: `state_freq`=0, `state_amp`=1, `state_phase`=0, `gen_en`=0, `busy`=0, `dir_down`=0, `done`=0, FSM=IDLE.
- FSM states: IDLE, LOAD, DWELL, STEP, DONE.
- IDLE:
  - Outputs hold their last values; `gen_en`=0.
  - `start`=1 -> LOAD.
- LOAD (1 cycle):
  - Shadow-register all `cfg_*`; later `cfg_*` changes have no effect until the next `start`.
  - `state_freq`<=`cfg_start_freq`; `lo`/`hi` endpoints latched.
  - `dir_down`<=(`cfg_stop_freq` < `cfg_start_freq`).
  - `state_amp`<=`cfg_amp`, except 0 is clamped to 1 (the generator divides by `state_amp`).
  - `state_phase`<=`cfg_phase`.
  - Dwell counter<=D-1, where D=max(`cfg_dwell`,1).
  - -> DWELL.
- `gen_en`=1 exactly in DWELL and STEP. First enabled cycle is 2 cycles after the edge that samples `start`.
- DWELL: counter decrements each cycle; at 0 -> STEP.
- STEP (1 cycle, counts as the last cycle of the hold): each `state_freq` value is visible with `gen_en`=1 for exactly D cycles (D-1 in DWELL plus 1 in STEP; D=1 means STEP only).
  - Target = current leg end.
  - If `state_freq` != target: next = `state_freq` ± `cfg_step`. Compute in FREQ_W+1 bits; if next passes target (or wraps), saturate to target. Reload counter, -> DWELL.
  - If `state_freq` == target (end of leg):
    - single: -> DONE.
    - continuous: `state_freq`<=start value, direction unchanged, -> DWELL.
    - bidirectional: toggle `dir_down`, swap target, step one increment back toward the other end (saturating), -> DWELL. End points are not repeated.
- `cfg_step`=0 with start≠stop: behaves as step to target in one STEP (saturation rule). `cfg_start_freq`=`cfg_stop_freq`: every STEP is end-of-leg.
- DONE (1 cycle): `done`=1, `gen_en`=0 -> IDLE.
- `stop_req` in any non-IDLE state:
  - Next state IDLE, `gen_en`=0 next cycle, no `done` pulse, `state_freq` holds.
  - `stop_req` in IDLE is ignored.
- `start` while busy: ignored.
- `start` and `stop_req` together: in IDLE, stay IDLE (stop wins); otherwise abort.
- `rst` mid-sweep: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package `awg_pkg`:
  - FSM state encoding constants.
  - `cfg_mode` encodings (MODE_SINGLE, MODE_CONT, MODE_BIDIR).
  - FREQ_W default.
- One natural sub-module, `sweep_step_calc`: combinational saturating ±step vs. target, outputs next value and at_target flag.
- FSM and counters stay in the top module.

Test Plan:
- Up single sweep: start=100, stop=130, step=10, dwell=3, mode=0.
  - `state_freq` = 100,110,120,130, each held 3 cycles with `gen_en`=1.
  - Then `done` pulses 1 cycle and `gen_en`=0.
  - 12 enabled cycles total.
- Down with saturation: start=50, stop=5, step=20, dwell=1.
  - Sequence 50,30,10,5.
  - `dir_down`=1 throughout.
  - `done` after 4 enabled cycles.
- Bidirectional: start=0, stop=4, step=2, dwell=1, mode=2.
  - Sequence 0,2,4,2,0,2,4…
  - `dir_down` toggles on leaving 4 and 0.
  - `stop_req` at arbitrary point -> `gen_en`=0 next cycle, no `done`.
- Continuous plus shadowing: start=10, stop=12, step=1, mode=1.
  - Sequence 10,11,12,10,11…
  - Changing `cfg_stop_freq` mid-sweep has no effect.
- Edge cases: `cfg_amp`=0 -> `state_amp`=1. dwell=0 -> each point held 1 cycle. start=stop=7 in single -> one point, then `done`.
- Control conflicts:
  - `start`+`stop_req` same cycle in IDLE -> remains IDLE.
  - `start` during busy ignored.
  - `rst` asserted mid-DWELL -> outputs at reset values before next clk edge.
